bus_gnrtr_n_rbtr: RTL and testbench

//  Shared-bus generator and arbiter for N device FIFOs on one or more parallel buses.
//  Per bus: picks one device with a pending packet, pops that packet, decodes its destination
//  and pushes it to the destination device (or to all others on broadcast). Sits between the device FIFOs.

---
 rtl/bs_pkg.sv | 23 ++
 rtl/bs_rr_arbiter.sv | 68 ++++++
 rtl/bus_gnrtr_n_rbtr.sv | 107 ++++++++++
 tb/tb_bus_gnrtr_n_rbtr.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types and helpers for the bus generator / arbiter.
// Holds the FSM state enum, address width and destination decode helper.
package bs_pkg;

    localparam int ADDR_W    = 8;
    localparam int PKT_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } bs_state_t;

    // Destination ID sits in the top ADDR_W bits of a packet of
    // width 'width'; the packet is passed zero-extended.
    function automatic logic [ADDR_W-1:0] get_dest(
        input logic [PKT_MAX_W-1:0] pkt,
        input int                   width
    );
        return pkt[width-1 -: ADDR_W];
    endfunction

endpackage

// File: rtl/bs_rr_arbiter.sv
// Per-bus requester arbiter: one-hot grant plus grant index.
// Ports: clk, rst_n, req_i, upd_i (commit grant), gnt_o, idx_o, any_o.
// BS_FIXED_PRIO_EN: lowest pending index wins, no pointer state.
module bs_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

`ifdef BS_FIXED_PRIO_EN

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[k]) begin
                any_o = 1'b1;
                idx_o = IW'(k);
            end
        end
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

`else

    // ptr_q is the first index searched, i.e. last grant + 1.
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int c;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (!any_o && req_i[c]) begin
                any_o = 1'b1;
                idx_o = IW'(c);
            end
        end
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i && any_o) begin
            if (int'(idx_o) == N - 1) ptr_d = '0;
            else ptr_d = idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end

`endif

endmodule

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus generator: per bus, arbitrate, pop a packet, route it.
// Ports: clk, reset (async low), pndng/D_pop in, pop/push/D_push out.
// BS_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module bus_gnrtr_n_rbtr
    import bs_pkg::*;
#(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bs_state_t          state_q;
        logic [IW-1:0]      src_q;
        logic [drvrs-1:0]   pop_q;
        logic [drvrs-1:0]   push_q;
        logic [pckg_sz-1:0] pkt_q;

        logic [drvrs-1:0]   gnt;
        logic [IW-1:0]      gidx;
        logic               any;
        logic [pckg_sz-1:0] head;
        logic [ADDR_W-1:0]  dest;
        logic [drvrs-1:0]   route;

        bs_rr_arbiter #(
            .N  (drvrs),
            .IW (IW)
        ) u_arb (
            .clk   (clk),
            .rst_n (reset),
            .req_i (pndng[b]),
            .upd_i (state_q == IDLE),
            .gnt_o (gnt),
            .idx_o (gidx),
            .any_o (any)
        );

        assign head = D_pop[b][src_q];
        assign dest = get_dest(PKT_MAX_W'(head), pckg_sz);

        // Broadcast skips the sender; unknown IDs route nowhere.
        always_comb begin
            route = '0;
            for (int i = 0; i < drvrs; i++) begin
                if (dest == broadcast)
                    route[i] = (i != int'(src_q));
                else if (int'(dest) < drvrs)
                    route[i] = (i == int'(dest));
            end
        end

        // Packet is captured while pop is high so push lands one
        // cycle after pop; PUSH is the cycle push is visible.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                src_q   <= '0;
                pop_q   <= '0;
                push_q  <= '0;
                pkt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        push_q <= '0;
                        if (any) begin
                            pop_q   <= gnt;
                            src_q   <= gidx;
                            state_q <= POP;
                        end
                    end
                    POP: begin
                        pop_q   <= '0;
                        pkt_q   <= head;
                        push_q  <= route;
                        state_q <= PUSH;
                    end
                    PUSH: begin
                        push_q  <= '0;
                        state_q <= IDLE;
                    end
                    default: begin
                        pop_q   <= '0;
                        push_q  <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign pop[b]    = pop_q;
        assign push[b]   = push_q;
        assign D_push[b] = {drvrs{pkt_q}};
    end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Directed bench for bus_gnrtr_n_rbtr, 5 devices, broadcast 8'h8F.
// Honours BS_FIXED_PRIO_EN for arbitration expectations.
module tb_bus_gnrtr_n_rbtr;

    localparam int BITS = 1;
    localparam int DR   = 5;
    localparam int PW   = 16;

    logic                            clk;
    logic                            reset;
    logic [BITS-1:0][DR-1:0]         pndng;
    logic [BITS-1:0][DR-1:0][PW-1:0] D_pop;
    logic [BITS-1:0][DR-1:0]         pop;
    logic [BITS-1:0][DR-1:0]         push;
    logic [BITS-1:0][DR-1:0][PW-1:0] D_push;

    int checks = 0;
    int errors = 0;

    bus_gnrtr_n_rbtr #(
        .bits      (BITS),
        .drvrs     (DR),
        .pckg_sz   (PW),
        .broadcast (8'h8F)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DR*PW-1:0] rep(input logic [PW-1:0] v);
        return {DR{v}};
    endfunction

    logic [DR-1:0] exp_g;
    logic [DR-1:0] exp_p;

    initial begin
        reset = 1'b0;
        pndng = '1;
        D_pop = '0;

        // reset held with all requests pending
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_pop", pop, 0);
            chk("rst_push", push, 0);
            chk("rst_dpush", D_push, 0);
        end
        pndng = '0;
        reset = 1'b1;
        tick();
        chk("idle_pop", pop, 0);

        // unicast 1 -> 3
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h03AB;
        tick();
        chk("uc_pop", pop, 5'b00010);
        pndng = '0;
        tick();
        chk("uc_pop_off", pop, 0);
        chk("uc_push", push, 5'b01000);
        chk("uc_dpush", D_push, rep(16'h03AB));
        tick();
        chk("uc_push_off", push, 0);

        // broadcast from 2
        pndng[0][2] = 1'b1;
        D_pop[0][2] = 16'h8F55;
        tick();
        chk("bc_pop", pop, 5'b00100);
        pndng = '0;
        tick();
        chk("bc_push", push, 5'b11011);
        chk("bc_dpush", D_push, rep(16'h8F55));
        tick();
        chk("bc_push_off", push, 0);
        chk("bc_dpush_hold", D_push, rep(16'h8F55));

        // invalid destination from 4
        pndng[0][4] = 1'b1;
        D_pop[0][4] = 16'h0712;
        tick();
        chk("inv_pop", pop, 5'b10000);
        pndng = '0;
        tick();
        chk("inv_push", push, 0);
        tick();
        chk("inv_push2", push, 0);

        // 0 and 3 held pending: 0 sends to 3, 3 sends to 0
        D_pop[0][0] = 16'h0311;
        D_pop[0][3] = 16'h0022;
        pndng = 5'b01001;
        for (int r = 0; r < 4; r++) begin
`ifdef BS_FIXED_PRIO_EN
            exp_g = 5'b00001;
`else
            exp_g = (r % 2 == 0) ? 5'b00001 : 5'b01000;
`endif
            exp_p = (exp_g == 5'b00001) ? 5'b01000 : 5'b00001;
            tick();
            chk("rr_pop", pop, exp_g);
            tick();
            chk("rr_push", push, exp_p);
            tick();
            chk("rr_gap", pop, 0);
        end

        // reset while in POP; grant must restart from device 0
        D_pop[0][4] = 16'h0100;
        pndng = 5'b11001;
        tick();
`ifdef BS_FIXED_PRIO_EN
        chk("mid_pop", pop, 5'b00001);
`else
        chk("mid_pop", pop, 5'b10000);
`endif
        reset = 1'b0;
        #1;
        chk("mid_rst_pop", pop, 0);
        tick();
        chk("mid_rst_push", push, 0);
        reset = 1'b1;
        tick();
        chk("post_pop", pop, 5'b00001);
        chk("post_nopush", push, 0);
        tick();
        chk("post_push", push, 5'b01000);
        chk("post_dpush", D_push, rep(16'h0311));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
